// File: rtl/lebug_pkg.sv
// Shared definitions for the trace buffer.
//   tb_state_t - trace buffer control state
//   cnt_bits   - width of an occupancy counter able to hold 0..entries
//   ptr_bits   - width of an index into a buffer of 'entries' slots
package lebug_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } tb_state_t;

  function automatic int unsigned cnt_bits(input int unsigned entries);
    return $clog2(entries + 1);
  endfunction

  function automatic int unsigned ptr_bits(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/trace_buffer_ram.sv
// Simple dual-port storage for the trace buffer: one write port, one read port with a
// registered (1-cycle) output. No reset; contents are undefined until written.
//   clk   - clock
//   we    - write enable, writes wdata to mem[waddr]
//   re    - read enable, rdata <= mem[raddr] on the next edge (rdata holds otherwise)
module trace_buffer_ram #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_buffer.sv
// Circular trace memory. While tracing, every valid packed vector is captured, overwriting
// the oldest once TB_SIZE entries are held. A drain request (with tracing low) streams the
// held vectors oldest-first over a valid/ready interface.
//   tracing, valid_in, vector_in - capture side
//   drain_req                    - pulse to start readout
//   vector_out, valid_out, out_ready - readout stream
//   drain_done - one-cycle pulse after the final handshake (or after an empty drain_req)
//   count      - entries currently held
//   wrapped    - an entry was overwritten since the last drain/reset
//   dropped    - sticky: a vector arrived while draining
module trace_buffer
  import lebug_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TB_SIZE    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tracing,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH*N-1:0]      vector_in,
  input  logic                         drain_req,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*N-1:0]      vector_out,
  output logic                         valid_out,
  output logic                         drain_done,
  output logic [$clog2(TB_SIZE+1)-1:0] count,
  output logic                         wrapped,
  output logic                         dropped
);

  localparam int unsigned VecW = DATA_WIDTH * N;
  localparam int unsigned PtrW = ptr_bits(TB_SIZE);
  localparam int unsigned CntW = cnt_bits(TB_SIZE);

  tb_state_t       state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] fetch_left_q, fetch_left_d;  // entries not yet read from the RAM
  logic            wrapped_q, wrapped_d;
  logic            dropped_q, dropped_d;
  logic            done_q, done_d;

  // Read pipeline: RAM output stage -> prefetch (skid) slot -> output register.
  logic            rd_v_q;
  logic            skid_v_q, skid_v_d;
  logic [VecW-1:0] skid_q, skid_d;
  logic            out_v_q, out_v_d;
  logic [VecW-1:0] out_q, out_d;
  logic [VecW-1:0] rd_data;

  logic            wr_en;
  logic            rd_en;
  logic            accept;
  logic            out_free;
  logic [1:0]      occ;

  always_comb begin
    accept = out_v_q & out_ready;
    wr_en  = (state_q == IDLE) & tracing & valid_in;
    // Items that will sit in out/skid after this edge. A read issued now lands one edge
    // later; allowing at most one keeps the worst case (no accept next cycle) within the
    // two slots, while steady-state streaming never bubbles.
    occ    = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_v_q} - {1'b0, accept};
    rd_en  = (state_q == DRAIN) && (fetch_left_q != '0) && (occ <= 2'd1);
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fetch_left_d = fetch_left_q;
    wrapped_d    = wrapped_q;
    dropped_d    = dropped_q;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PtrW'(1);
          if (count_q == CntW'(TB_SIZE)) wrapped_d = 1'b1;
          else                           count_d   = count_q + CntW'(1);
        end
        if (drain_req && !tracing) begin
          if (count_q != '0) begin
            state_d      = DRAIN;
            // Oldest entry; a full buffer subtracts TB_SIZE, i.e. starts at wr_ptr.
            rd_ptr_d     = wr_ptr_q - count_q[PtrW-1:0];
            fetch_left_d = count_q;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (tracing && valid_in) dropped_d = 1'b1;
        if (rd_en) begin
          rd_ptr_d     = rd_ptr_q + PtrW'(1);
          fetch_left_d = fetch_left_q - CntW'(1);
        end
        if (accept) begin
          count_d = count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_d   = IDLE;
            wrapped_d = 1'b0;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_free = !out_v_q || accept;
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (out_free) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = rd_v_q;
        skid_d   = rd_data;
      end else if (rd_v_q) begin
        out_v_d = 1'b1;
        out_d   = rd_data;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (rd_v_q) begin
      skid_v_d = 1'b1;
      skid_d   = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fetch_left_q <= '0;
      wrapped_q    <= 1'b0;
      dropped_q    <= 1'b0;
      done_q       <= 1'b0;
      rd_v_q       <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_q       <= '0;
      out_v_q      <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fetch_left_q <= fetch_left_d;
      wrapped_q    <= wrapped_d;
      dropped_q    <= dropped_d;
      done_q       <= done_d;
      rd_v_q       <= rd_en;
      skid_v_q     <= skid_v_d;
      skid_q       <= skid_d;
      out_v_q      <= out_v_d;
      out_q        <= out_d;
    end
  end

  trace_buffer_ram #(
    .Width (VecW),
    .Depth (TB_SIZE),
    .AddrW (PtrW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (vector_in),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign vector_out = out_q;
  assign valid_out  = out_v_q;
  assign drain_done = done_q;
  assign count      = count_q;
  assign wrapped    = wrapped_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_trace_buffer.sv
module tb_trace_buffer;

  localparam int unsigned N   = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned TBS = 16;
  localparam int unsigned VW  = N * DW;
  localparam int unsigned CW  = $clog2(TBS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tracing;
  logic          valid_in;
  logic [VW-1:0] vector_in;
  logic          drain_req;
  logic          out_ready;
  logic [VW-1:0] vector_out;
  logic          valid_out;
  logic          drain_done;
  logic [CW-1:0] count;
  logic          wrapped;
  logic          dropped;

  int checks = 0;
  int errors = 0;

  trace_buffer #(
    .N          (N),
    .DATA_WIDTH (DW),
    .TB_SIZE    (TBS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .drain_req  (drain_req),
    .out_ready  (out_ready),
    .vector_out (vector_out),
    .valid_out  (valid_out),
    .drain_done (drain_done),
    .count      (count),
    .wrapped    (wrapped),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic tr;
    logic vi;
    int   k;
    logic dr;
    logic rdy;
    logic e_valid;
    int   e_k;
    logic e_done;
    int   e_count;
    logic e_wrapped;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [VW-1:0] make_vec(input int k);
    logic [VW-1:0] v;
    for (int l = 0; l < int'(N); l++) v[l*DW +: DW] = DW'(k * 10 + l);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] exp);
    checks++;
    if (vector_out !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, vector_out, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int first_k, input int n);
    tracing  = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      vector_in = make_vec(first_k + i);
      step();
    end
    tracing  = 1'b0;
    valid_in = 1'b0;
  endtask

  // Pulse drain_req, then consume until stop_after vectors are accepted. With toggle, the
  // consumer's ready follows 1,0,0,1. inject raises tracing+valid_in for the first cycles.
  task automatic drain(input int first_k, input int n, input bit toggle, input int inject,
                       input int stop_after, input bit exp_wr);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    drain_req = 1'b1;
    tracing   = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b1;
    step();
    drain_req = 1'b0;
    while (got < stop_after && cyc < 200) begin
      tracing   = (cyc < inject);
      valid_in  = (cyc < inject);
      vector_in = '1;
      out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled) check("stall_valid_held", int'(valid_out), 1);
      if (valid_out) begin
        check("drain_count", int'(count), n - got);
        check("drain_wrapped", int'(wrapped), int'(exp_wr));
        check_vec("drain_data", make_vec(first_k + got));
        if (out_ready) begin
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
      step();
      cyc++;
    end
    tracing   = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b1;
    check("drain_accepted", got, stop_after);
    if (stop_after == n) begin
      check("done_pulse", int'(drain_done), 1);
      check("done_valid_low", int'(valid_out), 0);
      check("done_count", int'(count), 0);
      check("done_wrapped", int'(wrapped), 0);
      step();
      check("done_one_cycle", int'(drain_done), 0);
      check("after_valid_low", int'(valid_out), 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tracing   = 1'b0;
    valid_in  = 1'b0;
    vector_in = '0;
    drain_req = 1'b0;
    out_ready = 1'b1;

    // Basic capture of 5, drain with ready high; one row per clock.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b1, i, 1'b0, 1'b1, 1'b0, 0, 1'b0, i + 1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 5, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 5, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 5, 1'b0};
    for (int i = 8; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, i - 7, 1'b0, 12 - i, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0};

    step();
    step();
    check("rst_valid", int'(valid_out), 0);
    check("rst_count", int'(count), 0);
    check("rst_wrapped", int'(wrapped), 0);
    check("rst_dropped", int'(dropped), 0);
    check("rst_done", int'(drain_done), 0);
    check_vec("rst_vector", '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      tracing   = tbl[i].tr;
      valid_in  = tbl[i].vi;
      vector_in = make_vec(tbl[i].k);
      drain_req = tbl[i].dr;
      out_ready = tbl[i].rdy;
      step();
      check($sformatf("t1_valid[%0d]", i), int'(valid_out), int'(tbl[i].e_valid));
      check($sformatf("t1_done[%0d]", i), int'(drain_done), int'(tbl[i].e_done));
      check($sformatf("t1_count[%0d]", i), int'(count), tbl[i].e_count);
      check($sformatf("t1_wrapped[%0d]", i), int'(wrapped), int'(tbl[i].e_wrapped));
      if (tbl[i].e_valid) check_vec($sformatf("t1_data[%0d]", i), make_vec(tbl[i].e_k));
    end
    tracing   = 1'b0;
    valid_in  = 1'b0;
    drain_req = 1'b0;

    // Overfill: 20 captured, oldest 4 lost.
    capture(0, 20);
    check("wrap_count", int'(count), 16);
    check("wrap_flag", int'(wrapped), 1);
    drain(4, 16, 1'b0, 0, 16, 1'b1);

    // Exactly full, no wrap; drain with stalls.
    capture(100, 16);
    check("full_count", int'(count), 16);
    check("full_no_wrap", int'(wrapped), 0);
    drain(100, 16, 1'b1, 0, 16, 1'b0);

    // drain_req while tracing is ignored.
    capture(500, 3);
    tracing   = 1'b1;
    drain_req = 1'b1;
    step();
    tracing   = 1'b0;
    drain_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("trace_req_ignored_valid", int'(valid_out), 0);
      check("trace_req_ignored_count", int'(count), 3);
      step();
    end
    capture(503, 1);
    check("still_idle_count", int'(count), 4);
    drain(500, 4, 1'b0, 0, 4, 1'b0);

    // Empty drain: done pulse, no data.
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    check("empty_done", int'(drain_done), 1);
    check("empty_valid", int'(valid_out), 0);
    step();
    check("empty_done_once", int'(drain_done), 0);
    check("empty_valid2", int'(valid_out), 0);
    check("pre_drop_flag", int'(dropped), 0);

    // Input arriving during drain sets dropped and is not stored.
    capture(200, 6);
    drain(200, 6, 1'b0, 3, 6, 1'b0);
    check("dropped_set", int'(dropped), 1);
    step();
    step();
    check("dropped_sticky", int'(dropped), 1);

    // Reset in the middle of a drain.
    capture(300, 8);
    drain(300, 8, 1'b0, 0, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(valid_out), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_dropped", int'(dropped), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("postrst_done", int'(drain_done), 0);
    capture(400, 2);
    check("postrst_count", int'(count), 2);
    drain(400, 2, 1'b0, 0, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_buffer.md
# trace_buffer

Circular on-chip trace memory directly downstream of the data packer. While tracing, it captures every full N-wide packed vector presented to it, overwriting the oldest entry once TB_SIZE entries are held. When tracing stops, a drain request streams the held vectors out, oldest to newest, over a valid/ready interface toward the host readout path.

## Interface
- N, 8, vector width in lanes; must match the packer's N
- DATA_WIDTH, 32, bits per lane
- TB_SIZE, 16, entries held; power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- tracing  in  1  capture enable
- valid_in  in  1  vector_in holds a packed vector this cycle
- vector_in  in  DATA_WIDTH×N  packed vector, lane 0 = oldest value
- drain_req  in  1  one-cycle pulse: start readout
- out_ready  in  1  consumer accepts vector_out this cycle
- vector_out  out  DATA_WIDTH×N  drained vector
- valid_out  out  1  vector_out valid
- drain_done  out  1  one-cycle pulse after last drained vector is accepted
- count  out  $clog2(TB_SIZE+1)  entries currently held
- wrapped  out  1  at least one entry was overwritten since last drain/reset
- dropped  out  1  sticky: a valid_in arrived during DRAIN

## Operation
- States: IDLE, DRAIN.
- IDLE, tracing=1, valid_in=1: write vector_in at wr_ptr; wr_ptr ← wr_ptr+1 mod TB_SIZE; count ← min(count+1, TB_SIZE); if count was TB_SIZE, wrapped ← 1 (oldest entry lost).
- valid_in with tracing=0 is ignored, no flag.
- IDLE → DRAIN on drain_req=1 with tracing=0 and count>0. drain_req with tracing=1 or count=0 ignored; count=0 with tracing=0 pulses drain_done next cycle, no data.
- Drain start pointer = wr_ptr − count mod TB_SIZE (oldest). Each accepted output (valid_out & out_ready) advances read pointer and decrements count.
- DRAIN → IDLE when the last entry is accepted; same edge: count=0, wrapped ← 0, drain_done pulses next cycle.
- In DRAIN, valid_in is not written; if tracing=1 and valid_in=1, dropped ← 1. Raising tracing does not abort the drain.
- dropped clears only on reset.
- Reset (any time, including mid-drain): state IDLE, pointers 0, count 0, wrapped 0, dropped 0, valid_out 0, drain_done 0, vector_out all zero. Memory contents not cleared and not reachable afterward.

## Timing
- Write: vector accepted at edge t is reflected in count after edge t.
- Memory read: synchronous, 1 cycle.
- drain_req sampled at edge t → first valid_out high after edge t+2.
- With out_ready held high, one vector per cycle, no bubbles; TB_SIZE entries drain in TB_SIZE cycles after the first.
- valid_out, once high, stays high and vector_out stable until accepted. out_ready low stalls without loss or duplication, using a prefetch slot.
- drain_done high exactly one cycle, the cycle after the final handshake; valid_out low in that cycle.

## Structure
- Shared package lebug_pkg: tb_state_t enum {IDLE, DRAIN}, and the function used to size count and pointers from TB_SIZE.
- Sub-module trace_buffer_ram: simple dual-port TB_SIZE × (N·DATA_WIDTH), one write port, 1-cycle registered read port, no reset.

## Test plan
- N=8, TB_SIZE=16: capture 5 vectors with lane values k·10+lane (k=0..4), drop tracing, pulse drain_req, out_ready=1 → valid_out first at +2 cycles, 5 consecutive vectors k=0..4, drain_done one cycle later, count=0, wrapped=0.
- Capture 20 vectors (k=0..19) → count=16, wrapped=1; drain yields k=4..19 in order; wrapped clears after last handshake.
- Drain 16 entries with out_ready toggled 1,0,0,1 repeating → each vector seen exactly once, vector_out stable while stalled, order preserved.
- drain_req while tracing=1 → ignored, state IDLE, count unchanged; drain_req with count=0, tracing=0 → no valid_out, drain_done pulses next cycle.
- During drain, raise tracing with valid_in=1 for 3 cycles → dropped=1, count unaffected by those inputs, drain completes normally; dropped stays 1 until reset.
- Assert rst_n=0 mid-drain after 3 of 8 vectors → valid_out=0, count=0, state IDLE immediately; after release, new capture of 2 vectors drains only those 2.
